// File: rtl/cmd_parser.sv
// ----------------------------------------------------------------------------
// cmd_parser
//   Byte-stream front end for cmd_factory. Frames received link bytes into
//   {dev,mod,addr,data} commands (one-cycle cmd_vld strobe) and returns each
//   cmd_q result to the host as a two-byte reply {RHEAD, q} over a valid/ready
//   TX byte interface. RX framing and TX reply paths are fully independent.
//
//   Optional feature macro: CMD_PARSER_CHK_EN
//     defined   : 6-byte frame HEAD,dev,mod,addr,data,chk where
//                 chk = (dev+mod+addr+data) mod 256; mismatch -> err_chk.
//     undefined : 5-byte frame HEAD,dev,mod,addr,data; err_chk tied low.
//
// Ports
//   clk_sys             system clock, rising edge
//   rst_n               asynchronous active-low reset
//   rx_data/rx_vld      received byte, 1-cycle valid pulse per byte
//   cmd_dev/mod/addr/data  last good command (held until next good frame)
//   cmd_vld             1-cycle command strobe
//   cmd_q/cmd_qvld      command result, 1-cycle valid pulse
//   tx_data/tx_vld/tx_rdy  reply byte stream, transfer on tx_vld & tx_rdy
//   err_chk             1-cycle pulse: checksum mismatch
//   err_tmo             1-cycle pulse: inter-byte timeout inside a frame
//   err_ovf             1-cycle pulse: cmd_qvld dropped while reply busy
// ----------------------------------------------------------------------------
module cmd_parser #(
  parameter logic [7:0]       HEAD    = 8'hA5,
  parameter logic [7:0]       RHEAD   = 8'h5A,
  parameter int               TMO_W   = 16,
  parameter logic [TMO_W-1:0] TMO_CYC = 16'd50000
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_vld,
  output logic [7:0] cmd_dev,
  output logic [7:0] cmd_mod,
  output logic [7:0] cmd_addr,
  output logic [7:0] cmd_data,
  output logic       cmd_vld,
  input  logic [7:0] cmd_q,
  input  logic       cmd_qvld,
  output logic [7:0] tx_data,
  output logic       tx_vld,
  input  logic       tx_rdy,
  output logic       err_chk,
  output logic       err_tmo,
  output logic       err_ovf
);

  localparam logic [2:0] R_IDLE = 3'd0;
  localparam logic [2:0] R_DEV  = 3'd1;
  localparam logic [2:0] R_MOD  = 3'd2;
  localparam logic [2:0] R_ADDR = 3'd3;
  localparam logic [2:0] R_DATA = 3'd4;
`ifdef CMD_PARSER_CHK_EN
  localparam logic [2:0] R_CHK  = 3'd5;
`endif

  localparam logic [1:0] T_IDLE = 2'd0;
  localparam logic [1:0] T_HEAD = 2'd1;
  localparam logic [1:0] T_Q    = 2'd2;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_CYC - TMO_W'(1);

`ifdef CMD_PARSER_CHK_EN
  // Frame checksum: modulo-256 sum of the four command fields.
  function automatic logic [7:0] f_sum(input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] c, input logic [7:0] d);
    f_sum = a + b + c + d;
  endfunction
`endif

  // RX state
  logic [2:0]       r_rx_st;
  logic [TMO_W-1:0] r_tmo_cnt;
  logic [7:0]       r_dev;
  logic [7:0]       r_mod;
  logic [7:0]       r_addr;
`ifdef CMD_PARSER_CHK_EN
  logic [7:0]       r_data;
`endif
  logic [7:0]       r_cmd_dev;
  logic [7:0]       r_cmd_mod;
  logic [7:0]       r_cmd_addr;
  logic [7:0]       r_cmd_data;
  logic             r_cmd_vld;
  logic             r_err_chk;
  logic             r_err_tmo;

  // TX state
  logic [1:0]       r_tx_st;
  logic [7:0]       r_q;
  logic [7:0]       r_tx_data;
  logic             r_tx_vld;
  logic             r_err_ovf;

  // A byte arriving on the expiry cycle takes priority over the timeout.
  logic w_tmo;
  assign w_tmo = (r_rx_st != R_IDLE) && !rx_vld && (r_tmo_cnt == TMO_LAST);

  // Inter-byte timeout counter: idle or any received byte restarts it.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt <= '0;
    end else if ((r_rx_st == R_IDLE) || rx_vld || w_tmo) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
    end
  end

  // RX framing FSM, field capture and registered command/error outputs.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_st    <= R_IDLE;
      r_dev      <= 8'h00;
      r_mod      <= 8'h00;
      r_addr     <= 8'h00;
`ifdef CMD_PARSER_CHK_EN
      r_data     <= 8'h00;
`endif
      r_cmd_dev  <= 8'h00;
      r_cmd_mod  <= 8'h00;
      r_cmd_addr <= 8'h00;
      r_cmd_data <= 8'h00;
      r_cmd_vld  <= 1'b0;
      r_err_chk  <= 1'b0;
      r_err_tmo  <= 1'b0;
    end else begin
      r_cmd_vld <= 1'b0;
      r_err_chk <= 1'b0;
      r_err_tmo <= 1'b0;
      if (w_tmo) begin
        // Partial frame is dropped; committed cmd_* fields are untouched.
        r_err_tmo <= 1'b1;
        r_rx_st   <= R_IDLE;
      end else if (rx_vld) begin
        case (r_rx_st)
          R_IDLE: begin
            // Non-header bytes between frames are silently discarded.
            if (rx_data == HEAD) begin
              r_rx_st <= R_DEV;
            end else begin
              r_rx_st <= R_IDLE;
            end
          end
          R_DEV: begin
            r_dev   <= rx_data;
            r_rx_st <= R_MOD;
          end
          R_MOD: begin
            r_mod   <= rx_data;
            r_rx_st <= R_ADDR;
          end
          R_ADDR: begin
            r_addr  <= rx_data;
            r_rx_st <= R_DATA;
          end
`ifdef CMD_PARSER_CHK_EN
          R_DATA: begin
            r_data  <= rx_data;
            r_rx_st <= R_CHK;
          end
          R_CHK: begin
            if (rx_data == f_sum(r_dev, r_mod, r_addr, r_data)) begin
              r_cmd_dev  <= r_dev;
              r_cmd_mod  <= r_mod;
              r_cmd_addr <= r_addr;
              r_cmd_data <= r_data;
              r_cmd_vld  <= 1'b1;
            end else begin
              r_err_chk  <= 1'b1;
            end
            r_rx_st <= R_IDLE;
          end
`else
          R_DATA: begin
            r_cmd_dev  <= r_dev;
            r_cmd_mod  <= r_mod;
            r_cmd_addr <= r_addr;
            r_cmd_data <= rx_data;
            r_cmd_vld  <= 1'b1;
            r_rx_st    <= R_IDLE;
          end
`endif
          default: begin
            r_rx_st <= R_IDLE;
          end
        endcase
      end else begin
        r_rx_st <= r_rx_st;
      end
    end
  end

  // TX reply FSM: header byte then latched result, each held until accepted.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_st   <= T_IDLE;
      r_q       <= 8'h00;
      r_tx_data <= 8'h00;
      r_tx_vld  <= 1'b0;
      r_err_ovf <= 1'b0;
    end else begin
      // Any result arriving while a reply is in flight is lost and flagged,
      // including on the cycle the final reply byte is accepted.
      r_err_ovf <= cmd_qvld && (r_tx_st != T_IDLE);
      case (r_tx_st)
        T_IDLE: begin
          if (cmd_qvld) begin
            r_q       <= cmd_q;
            r_tx_data <= RHEAD;
            r_tx_vld  <= 1'b1;
            r_tx_st   <= T_HEAD;
          end
        end
        T_HEAD: begin
          if (tx_rdy) begin
            r_tx_data <= r_q;
            r_tx_st   <= T_Q;
          end
        end
        T_Q: begin
          if (tx_rdy) begin
            r_tx_data <= 8'h00;
            r_tx_vld  <= 1'b0;
            r_tx_st   <= T_IDLE;
          end
        end
        default: begin
          r_tx_data <= 8'h00;
          r_tx_vld  <= 1'b0;
          r_tx_st   <= T_IDLE;
        end
      endcase
    end
  end

  assign cmd_dev  = r_cmd_dev;
  assign cmd_mod  = r_cmd_mod;
  assign cmd_addr = r_cmd_addr;
  assign cmd_data = r_cmd_data;
  assign cmd_vld  = r_cmd_vld;
  assign tx_data  = r_tx_data;
  assign tx_vld   = r_tx_vld;
  assign err_tmo  = r_err_tmo;
  assign err_ovf  = r_err_ovf;
`ifdef CMD_PARSER_CHK_EN
  assign err_chk  = r_err_chk;
`else
  assign err_chk  = 1'b0;
`endif

endmodule
